cp_fifo_reader: RTL and testbench



---
 rtl/cp_fifo_reader.sv | 211 +++++++++++++++++++++
 tb/tb_cp_fifo_reader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_fifo_reader.sv
// Read-side engine for the CP GX FIFO: tracks read pointer and read/write distance,
// fetches FIFO lines over AXI into a show-ahead buffer and streams them to the decoder.
module cp_fifo_reader #(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned ADDR_WIDTH  = 49,
    parameter int unsigned BURST_BEATS = 2,
    parameter int unsigned BUF_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           fifo_base,
    input  logic [31:0]           fifo_end,
    input  logic [31:0]           fifo_hi_wm,
    input  logic [31:0]           fifo_lo_wm,
    input  logic [31:0]           fifo_bp,
    input  logic [31:0]           fifo_axi_base,
    input  logic [31:0]           write_pointer,
    input  logic                  en_read,
    input  logic                  en_bp,
    input  logic                  new_base,
    input  logic                  clr_overflow,
    input  logic                  clr_underflow,
    input  logic                  clr_bp,
    output logic [31:0]           read_pointer,
    output logic [31:0]           rw_distance,
    output logic                  int_overflow,
    output logic                  int_underflow,
    output logic                  int_bp,
    output logic                  axi_error,
    output logic                  read_idle,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned BEAT_BYTES  = DATA_WIDTH / 8;
    localparam int unsigned BURST_BYTES = BURST_BEATS * BEAT_BYTES;
    localparam int unsigned IDX_W       = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W       = $clog2(BUF_DEPTH + 1);
    localparam logic [31:0] BURST_B32   = 32'(BURST_BYTES);
    localparam logic [31:0] ALIGN_MASK  = ~(BURST_B32 - 32'd1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HALT} state_t;

    state_t                  state_q, state_d;
    logic                    discard_q, discard_d;
    logic                    dist_stale_q;
    logic [31:0]             bp_q;
    logic                    issue, enter_halt;
    logic [31:0]             base_a, end_a, rp_d, dist_d, ar_sum;
    logic                    rp_chg, bp_hit, can_issue;
    logic                    ar_hs, r_hs, last_hs;
    logic                    ovf_set, unf_set;

    logic [DATA_WIDTH-1:0]   mem [BUF_DEPTH];
    logic [IDX_W-1:0]        wr_idx, rd_idx, next_rd;
    logic [CNT_W-1:0]        count_q, count_d, free_space;
    logic                    push, pop;
    logic [DATA_WIDTH-1:0]   out_data_d;

    assign arlen   = 8'(BURST_BEATS - 1);
    assign arsize  = 3'($clog2(BEAT_BYTES));
    assign arburst = 2'b01;

    assign base_a     = fifo_base & ALIGN_MASK;
    assign end_a      = fifo_end & ALIGN_MASK;
    assign ar_sum     = fifo_axi_base + read_pointer;
    assign ar_hs      = arvalid && arready;
    assign r_hs       = rready && rvalid;
    assign last_hs    = r_hs && rlast;
    assign bp_hit     = en_bp && (read_pointer == fifo_bp);
    assign free_space = CNT_W'(BUF_DEPTH) - count_q;
    // Issue uses the registered distance; skip the cycle where it still reflects the old pointer.
    assign can_issue  = en_read && !dist_stale_q && (rw_distance >= BURST_B32)
                        && (free_space >= CNT_W'(BURST_BEATS)) && !bp_hit;
    assign ovf_set    = rw_distance > fifo_hi_wm;
    assign unf_set    = (rw_distance < fifo_lo_wm) && en_read;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        issue      = 1'b0;
        enter_halt = 1'b0;
        case (state_q)
            IDLE: begin
                if (bp_hit) begin
                    state_d    = HALT;
                    enter_halt = 1'b1;
                end else if (can_issue && !new_base) begin
                    state_d = ADDR;
                    issue   = 1'b1;
                end
            end
            ADDR: begin
                if (new_base) discard_d = 1'b1;
                if (ar_hs)    state_d   = DATA;
            end
            DATA: begin
                if (last_hs) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end else if (new_base) begin
                    discard_d = 1'b1;
                end
            end
            HALT: begin
                if (!en_bp || (fifo_bp != bp_q)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer and distance; new_base beats a completing burst
    always_comb begin
        rp_d   = read_pointer;
        rp_chg = 1'b0;
        if (new_base) begin
            rp_d   = base_a;
            rp_chg = 1'b1;
        end else if (last_hs && !discard_q) begin
            rp_d   = (read_pointer == end_a) ? base_a : read_pointer + BURST_B32;
            rp_chg = 1'b1;
        end
        if (write_pointer >= read_pointer)
            dist_d = write_pointer - read_pointer;
        else
            dist_d = (end_a + BURST_B32 - read_pointer) + (write_pointer - base_a);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_q     <= 1'b0;
            dist_stale_q  <= 1'b0;
            bp_q          <= '0;
            read_pointer  <= '0;
            rw_distance   <= '0;
            araddr        <= '0;
            arvalid       <= 1'b0;
            rready        <= 1'b0;
            read_idle     <= 1'b1;
            int_overflow  <= 1'b0;
            int_underflow <= 1'b0;
            int_bp        <= 1'b0;
            axi_error     <= 1'b0;
        end else begin
            discard_q     <= discard_d;
            dist_stale_q  <= rp_chg;
            if (enter_halt) bp_q <= fifo_bp;
            read_pointer  <= rp_d;
            rw_distance   <= dist_d;
            if (issue) araddr <= ADDR_WIDTH'(ar_sum);
            arvalid       <= (state_d == ADDR);
            rready        <= (state_d == DATA);
            read_idle     <= ((state_d == IDLE) || (state_d == HALT)) && !discard_d;
            int_overflow  <= ovf_set | (int_overflow & ~clr_overflow);
            int_underflow <= unf_set | (int_underflow & ~clr_underflow);
            int_bp        <= enter_halt | (int_bp & ~clr_bp);
            if (r_hs && (rresp != 2'b00)) axi_error <= 1'b1;
        end
    end

    // Show-ahead buffer; out_data is pre-loaded from the entry that will be at the head
    assign push    = r_hs && !discard_q && !new_base;
    assign pop     = out_valid && out_ready;
    assign next_rd = pop ? rd_idx + IDX_W'(1) : rd_idx;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        out_data_d = mem[next_rd];
        if (push && (wr_idx == next_rd)) out_data_d = rdata;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= rdata;
    end

    always_ff @(posedge clk) begin
        if (reset || new_base) begin
            wr_idx    <= '0;
            rd_idx    <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            if (reset) out_data <= '0;
        end else begin
            if (push) wr_idx <= wr_idx + IDX_W'(1);
            rd_idx    <= next_rd;
            count_q   <= count_d;
            out_valid <= (count_d != '0);
            out_data  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_cp_fifo_reader.sv
// Randomized scoreboard bench for cp_fifo_reader: a behavioural AXI slave serves
// address-derived data while a monitor compares AR requests and output beats to a model.
module tb_cp_fifo_reader;

    localparam int unsigned BB         = 2;
    localparam logic [31:0] BASE       = 32'h0000_1000;
    localparam logic [31:0] FEND       = 32'h0000_10E0;
    localparam logic [31:0] AXI_BASE   = 32'h8000_0000;
    localparam logic [31:0] BURST_SZ   = 32'h20;

    logic         clk, reset;
    logic [31:0]  fifo_base, fifo_end, fifo_hi_wm, fifo_lo_wm, fifo_bp, fifo_axi_base, write_pointer;
    logic         en_read, en_bp, new_base, clr_overflow, clr_underflow, clr_bp;
    logic [31:0]  read_pointer, rw_distance;
    logic         int_overflow, int_underflow, int_bp, axi_error, read_idle;
    logic [48:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;
    logic [127:0] out_data;
    logic         out_valid, out_ready;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [31:0]  exp_ar[$];
    logic [127:0] exp_data[$];
    logic [31:0]  model_rp;
    logic [31:0]  err_addr;
    bit           slave_en, rand_ready;

    cp_fifo_reader dut (
        .clk(clk), .reset(reset),
        .fifo_base(fifo_base), .fifo_end(fifo_end), .fifo_hi_wm(fifo_hi_wm), .fifo_lo_wm(fifo_lo_wm),
        .fifo_bp(fifo_bp), .fifo_axi_base(fifo_axi_base), .write_pointer(write_pointer),
        .en_read(en_read), .en_bp(en_bp), .new_base(new_base),
        .clr_overflow(clr_overflow), .clr_underflow(clr_underflow), .clr_bp(clr_bp),
        .read_pointer(read_pointer), .rw_distance(rw_distance),
        .int_overflow(int_overflow), .int_underflow(int_underflow), .int_bp(int_bp),
        .axi_error(axi_error), .read_idle(read_idle),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] word(input logic [31:0] a);
        return {a ^ 32'h5A5A_5A5A, ~a, a + 32'h1234_5678, a};
    endfunction

    function automatic logic [31:0] model_dist(input logic [31:0] rp, input logic [31:0] wp);
        if (wp >= rp) return wp - rp;
        return (FEND + BURST_SZ - rp) + (wp - BASE);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the AR requests and beats the model predicts for n bursts from model_rp
    task automatic plan(input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = AXI_BASE + model_rp;
            exp_ar.push_back(a);
            for (int b = 0; b < int'(BB); b++) exp_data.push_back(word(a + 32'(b * 16)));
            model_rp = (model_rp == FEND) ? BASE : model_rp + BURST_SZ;
        end
    endtask

    task automatic plan_all();
        plan(int'(model_dist(model_rp, write_pointer) / BURST_SZ));
    endtask

    task automatic wait_done(input bit need_data);
        int cyc = 0;
        while (!(exp_ar.size() == 0 && read_idle && (!need_data || exp_data.size() == 0)) && cyc < 3000) begin
            step();
            cyc++;
        end
        chk("done_within_budget", 128'(cyc < 3000), 128'(1));
        repeat (6) step();
    endtask

    task automatic drive_beat(input logic [31:0] base_addr, input int beat);
        logic [31:0] a;
        a      = base_addr + 32'(beat * 16);
        rdata  = word(a);
        rresp  = (a == err_addr) ? 2'b10 : 2'b00;
        rlast  = (beat == int'(BB) - 1);
        rvalid = ($urandom_range(0, 2) != 0);
    endtask

    // Behavioural AXI read slave with random arready / rvalid timing
    initial begin : axi_slave
        logic        hs_ar, hs_r;
        int          beat;
        logic [31:0] cur;
        bit          busy;
        busy = 0; beat = 0; cur = '0;
        forever begin
            @(negedge clk);
            hs_ar = arvalid && arready;
            hs_r  = rvalid && rready;
            @(posedge clk);
            #1;
            if (!slave_en) begin
                busy = 0;
            end else if (busy) begin
                if (hs_r) beat++;
                if (beat == int'(BB)) begin
                    busy = 0; rvalid = 0; rlast = 0;
                end else if (!rvalid || hs_r) begin
                    drive_beat(cur, beat);
                end
            end else if (hs_ar) begin
                busy = 1; beat = 0; cur = araddr[31:0]; arready = 0;
                drive_beat(cur, 0);
            end else begin
                arready = ($urandom_range(0, 1) == 1);
                rvalid  = 0;
                rlast   = 0;
            end
        end
    end

    initial begin : ready_gen
        forever begin
            step();
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitor: compares every AR and output handshake against the queues
    always @(negedge clk) begin
        if (!reset) begin
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ar_unexpected: got araddr %h with no request expected", araddr);
                end else begin
                    chk("araddr", 128'(araddr), 128'(exp_ar.pop_front()));
                    chk("arlen", 128'(arlen), 128'(1));
                    chk("arsize", 128'(arsize), 128'(4));
                    chk("arburst", 128'(arburst), 128'(1));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: got %h with no beat expected", out_data);
                end else begin
                    chk("out_data", out_data, exp_data.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        reset = 1; en_read = 0; en_bp = 0; new_base = 0;
        clr_overflow = 0; clr_underflow = 0; clr_bp = 0;
        out_ready = 0; rand_ready = 0; slave_en = 0;
        arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = 2'b00;
        err_addr = 32'hFFFF_FFFF;
        fifo_base = BASE; fifo_end = FEND; fifo_hi_wm = 32'hFFFF_FFFF; fifo_lo_wm = 32'h0;
        fifo_bp = 32'h0; fifo_axi_base = AXI_BASE; write_pointer = BASE;
        model_rp = 32'h0;
        repeat (3) step();

        chk("rst_read_pointer", 128'(read_pointer), 128'(0));
        chk("rst_rw_distance", 128'(rw_distance), 128'(0));
        chk("rst_int_overflow", 128'(int_overflow), 128'(0));
        chk("rst_int_underflow", 128'(int_underflow), 128'(0));
        chk("rst_int_bp", 128'(int_bp), 128'(0));
        chk("rst_axi_error", 128'(axi_error), 128'(0));
        chk("rst_arvalid", 128'(arvalid), 128'(0));
        chk("rst_rready", 128'(rready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_read_idle", 128'(read_idle), 128'(1));

        reset = 0; slave_en = 1; rand_ready = 1;
        new_base = 1; step(); new_base = 0; model_rp = BASE;
        chk("newbase_load", 128'(read_pointer), 128'(BASE));

        // Basic fetch
        write_pointer = 32'h1040; plan_all(); en_read = 1;
        wait_done(1);
        chk("basic_read_pointer", 128'(read_pointer), 128'(32'h1040));
        chk("basic_rw_distance", 128'(rw_distance), 128'(0));
        chk("basic_read_idle", 128'(read_idle), 128'(1));

        // Wrap-around
        write_pointer = FEND; plan_all();
        wait_done(1);
        chk("wrap_pre_rp", 128'(read_pointer), 128'(FEND));
        en_read = 0; write_pointer = 32'h1020; repeat (3) step();
        chk("wrap_distance", 128'(rw_distance), 128'(32'h40));
        plan_all(); en_read = 1;
        wait_done(1);
        chk("wrap_read_pointer", 128'(read_pointer), 128'(32'h1020));
        chk("wrap_model_dist", 128'(rw_distance), 128'(model_dist(model_rp, write_pointer)));

        // Breakpoint
        en_read = 0; new_base = 1; step(); new_base = 0; model_rp = BASE;
        write_pointer = 32'h1080; fifo_bp = 32'h1020; en_bp = 1;
        plan(1); en_read = 1;
        wait_done(1);
        repeat (10) step();
        chk("bp_int_bp", 128'(int_bp), 128'(1));
        chk("bp_halt_rp", 128'(read_pointer), 128'(32'h1020));
        chk("bp_read_idle", 128'(read_idle), 128'(1));
        plan_all(); en_bp = 0;
        wait_done(1);
        chk("bp_resume_rp", 128'(read_pointer), 128'(32'h1080));
        chk("bp_sticky", 128'(int_bp), 128'(1));
        clr_bp = 1; step(); clr_bp = 0;
        chk("bp_clear", 128'(int_bp), 128'(0));

        // Watermarks and buffer-full stall
        en_read = 0; rand_ready = 0; out_ready = 0;
        new_base = 1; step(); new_base = 0; model_rp = BASE;
        fifo_hi_wm = 32'h60; write_pointer = 32'h10C0; step();
        chk("wm_distance", 128'(rw_distance), 128'(32'hC0));
        chk("wm_ovf_not_yet", 128'(int_overflow), 128'(0));
        clr_overflow = 1; step(); clr_overflow = 0;
        chk("wm_ovf_set_wins", 128'(int_overflow), 128'(1));
        plan(4); en_read = 1;
        wait_done(0);
        repeat (20) step();
        chk("wm_full_out_valid", 128'(out_valid), 128'(1));
        chk("wm_full_rp", 128'(read_pointer), 128'(32'h1080));
        plan(2); rand_ready = 1;
        wait_done(1);
        chk("wm_read_pointer", 128'(read_pointer), 128'(32'h10C0));
        chk("wm_ovf_sticky", 128'(int_overflow), 128'(1));
        clr_overflow = 1; step(); clr_overflow = 0;
        chk("wm_ovf_clear", 128'(int_overflow), 128'(0));
        fifo_lo_wm = 32'h20; step();
        chk("wm_unf_set", 128'(int_underflow), 128'(1));
        fifo_lo_wm = 32'h0; clr_underflow = 1; step(); clr_underflow = 0;
        chk("wm_unf_clear", 128'(int_underflow), 128'(0));

        // new_base between beat 0 and rlast
        slave_en = 0; rand_ready = 0; out_ready = 0; arready = 0; rvalid = 0; rlast = 0; en_read = 0;
        write_pointer = FEND; repeat (2) step();
        exp_ar.push_back(AXI_BASE + 32'h10C0);
        en_read = 1;
        cyc = 0;
        while (!arvalid && cyc < 20) begin step(); cyc++; end
        chk("nb_arvalid", 128'(arvalid), 128'(1));
        arready = 1; step(); arready = 0;
        rdata = word(AXI_BASE + 32'h10C0); rresp = 2'b00; rvalid = 1; rlast = 0; step(); rvalid = 0;
        chk("nb_beat0_visible", 128'(out_valid), 128'(1));
        new_base = 1; en_read = 0; step(); new_base = 0;
        chk("nb_flushed", 128'(out_valid), 128'(0));
        chk("nb_read_pointer", 128'(read_pointer), 128'(BASE));
        chk("nb_not_idle", 128'(read_idle), 128'(0));
        rdata = word(AXI_BASE + 32'h10D0); rvalid = 1; rlast = 1; step(); rvalid = 0; rlast = 0;
        chk("nb_idle_after_discard", 128'(read_idle), 128'(1));
        chk("nb_rp_not_advanced", 128'(read_pointer), 128'(BASE));
        step();
        chk("nb_discarded", 128'(out_valid), 128'(0));

        // Error response on beat 1 of the first burst from base
        model_rp = BASE; err_addr = AXI_BASE + 32'h1010; write_pointer = 32'h1040;
        slave_en = 1; rand_ready = 1; plan_all(); en_read = 1;
        wait_done(1);
        chk("err_axi_error", 128'(axi_error), 128'(1));
        chk("err_read_pointer", 128'(read_pointer), 128'(32'h1040));

        // Mid-burst reset
        err_addr = 32'hFFFF_FFFF; write_pointer = 32'h1080; plan_all();
        cyc = 0;
        while (!rready && cyc < 200) begin step(); cyc++; end
        chk("rst_reach_data", 128'(rready), 128'(1));
        reset = 1; slave_en = 0; arready = 0; rvalid = 0; rlast = 0; en_read = 0;
        rand_ready = 0; out_ready = 0;
        step();
        exp_ar.delete(); exp_data.delete();
        chk("mrst_read_pointer", 128'(read_pointer), 128'(0));
        chk("mrst_rw_distance", 128'(rw_distance), 128'(0));
        chk("mrst_axi_error", 128'(axi_error), 128'(0));
        chk("mrst_int_overflow", 128'(int_overflow), 128'(0));
        chk("mrst_arvalid", 128'(arvalid), 128'(0));
        chk("mrst_rready", 128'(rready), 128'(0));
        chk("mrst_out_valid", 128'(out_valid), 128'(0));
        chk("mrst_read_idle", 128'(read_idle), 128'(1));
        reset = 0; step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
